// File: rtl/mdu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl_pkg
//   Shared definitions for the HI/LO multiply/divide issue controller:
//   MDU op encodings, controller FSM state encodings and op-class helpers.
// ---------------------------------------------------------------------------
package mdu_issue_ctrl_pkg;

    // MDU operation codes as carried from the E stage to the MDU.
    typedef enum logic [2:0] {
        MDU_NOP = 3'd0,
        MULT    = 3'd1,
        MULTU   = 3'd2,
        DIV     = 3'd3,
        DIVU    = 3'd4,
        MTLO    = 3'd5,
        MTHI    = 3'd6
    } mdu_op_e;

    // Issue controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2
    } mdu_state_e;

    localparam int CNT_W = 4;

    // Ops that occupy the MDU for several cycles.
    function automatic logic is_muldiv(input mdu_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_mul(input mdu_op_e op);
        return (op == MULT) || (op == MULTU);
    endfunction

    // Single-cycle HI/LO writes that bypass the latency counter.
    function automatic logic is_mtx(input mdu_op_e op);
        return (op == MTLO) || (op == MTHI);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl_if
//   Pipeline <-> MDU issue controller signal bundle.
//   master : pipeline side (drives E/D-stage info, sees start/stall/status)
//   slave  : issue controller
//   e_valid, e_mdu_op, e_flush, d_uses_hilo  pipeline -> controller
//   mdu_start, mdu_ctrl, mdu_busy, mdu_done,
//   stall_d, stall_cycles, err_overlap       controller -> pipeline/MDU
// ---------------------------------------------------------------------------
interface mdu_issue_ctrl_if;
    import mdu_issue_ctrl_pkg::*;

    logic        e_valid;
    mdu_op_e     e_mdu_op;
    logic        e_flush;
    logic        d_uses_hilo;
    logic        mdu_start;
    mdu_op_e     mdu_ctrl;
    logic        mdu_busy;
    logic        mdu_done;
    logic        stall_d;
    logic [31:0] stall_cycles;
    logic        err_overlap;

    modport master (
        output e_valid, e_mdu_op, e_flush, d_uses_hilo,
        input  mdu_start, mdu_ctrl, mdu_busy, mdu_done,
               stall_d, stall_cycles, err_overlap
    );

    modport slave (
        input  e_valid, e_mdu_op, e_flush, d_uses_hilo,
        output mdu_start, mdu_ctrl, mdu_busy, mdu_done,
               stall_d, stall_cycles, err_overlap
    );

endinterface

// File: rtl/mdu_issue_ctrl_latency_counter.sv
// ---------------------------------------------------------------------------
// mdu_latency_counter
//   Down-counter tracking remaining MDU busy cycles. Loaded with the op's
//   latency on start, decrements to zero.
//   clk, reset    clock, synchronous active-high reset
//   i_load        load strobe (op start)
//   i_load_val    latency to load
//   o_busy        counter != 0
//   o_done        counter == 1 (last busy cycle, HI/LO written at its end)
//   o_gt1         counter > 1  (result not available next cycle)
// ---------------------------------------------------------------------------
module mdu_latency_counter
    import mdu_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_gt1
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_busy = (r_count != '0);
    assign o_done = (r_count == CNT_W'(1));
    assign o_gt1  = (r_count >  CNT_W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
//   Issues E-stage HI/LO ops to the multiply/divide unit, tracks its latency
//   and stalls D-stage HI/LO users until the result lands. Flushed E-stage
//   ops are dropped; an op already running is never cancelled.
//   Parameters: MULT_CYCLES, DIV_CYCLES  busy cycles per op class (1..15)
//   clk, reset  clock, synchronous active-high reset
//   bus         mdu_issue_ctrl_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    mdu_issue_ctrl_if.slave    bus
);

    // Latencies must fit the 4-bit counter and be non-zero.
    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
        $error("mdu_issue_ctrl: MULT_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("mdu_issue_ctrl: DIV_CYCLES must be in 1..15");
    end

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       r_state;
    logic             r_err_overlap;
    logic [31:0]      r_stall_cycles;

    logic             w_issue_ok;
    logic             w_is_muldiv;
    logic             w_start;
    logic             w_start_muldiv;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_busy;
    logic             w_cnt_done;
    logic             w_cnt_gt1;
    logic             w_stall;

    assign w_issue_ok  = bus.e_valid & ~bus.e_flush & (bus.e_mdu_op != MDU_NOP) & ~reset;
    assign w_is_muldiv = is_muldiv(bus.e_mdu_op);

    // MTLO/MTHI write HI/LO directly and may go while a mul/div runs;
    // mul/div must wait for the unit to be free.
    assign w_start        = w_issue_ok & (is_mtx(bus.e_mdu_op) | (w_is_muldiv & ~w_cnt_busy));
    assign w_start_muldiv = w_start & w_is_muldiv;
    assign w_load_val     = is_mul(bus.e_mdu_op) ? MULT_LOAD : DIV_LOAD;

    mdu_latency_counter u_latency (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_muldiv),
        .i_load_val (w_load_val),
        .o_busy     (w_cnt_busy),
        .o_done     (w_cnt_done),
        .o_gt1      (w_cnt_gt1)
    );

    // Stall lasts while the result is still more than one cycle away; it
    // drops in the done cycle so the D instruction reaches E after the write.
    assign w_stall = bus.d_uses_hilo & ~reset & (w_cnt_gt1 | w_start_muldiv);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_err_overlap  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_muldiv)
                        r_state <= is_mul(bus.e_mdu_op) ? ST_MUL_BUSY : ST_DIV_BUSY;
                end
                ST_MUL_BUSY, ST_DIV_BUSY: begin
                    if (w_cnt_done)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Sticky: a mul/div reached E while the unit was still busy.
            if (w_issue_ok & w_is_muldiv & w_cnt_busy)
                r_err_overlap <= 1'b1;

            if (w_stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.mdu_start    = w_start;
    assign bus.mdu_ctrl     = w_start ? bus.e_mdu_op : MDU_NOP;
    assign bus.mdu_busy     = w_cnt_busy;
    assign bus.mdu_done     = w_cnt_done & (r_state != ST_IDLE) & ~reset;
    assign bus.stall_d      = w_stall;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.err_overlap  = r_err_overlap;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl
//   Self-checking bench for mdu_issue_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Each table row gives the inputs for a cycle (repeated
//   'reps' times) and the outputs expected in that cycle.
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic clk;
    logic reset;

    mdu_issue_ctrl_if bus ();

    mdu_issue_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        mdu_op_e     op;
        logic        flush;
        logic        d_hilo;
        int          reps;
        logic        x_start;
        mdu_op_e     x_ctrl;
        logic        x_busy;
        logic        x_done;
        logic        x_stall;
        logic        x_err;
        logic [31:0] x_sc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic rst, input logic valid, input mdu_op_e op, input logic flush,
        input logic d_hilo, input int reps,
        input logic xs, input mdu_op_e xc, input logic xb, input logic xd,
        input logic xst, input logic xe, input logic [31:0] xsc);
        vec_t v;
        v.rst = rst; v.valid = valid; v.op = op; v.flush = flush; v.d_hilo = d_hilo;
        v.reps = reps; v.x_start = xs; v.x_ctrl = xc; v.x_busy = xb; v.x_done = xd;
        v.x_stall = xst; v.x_err = xe; v.x_sc = xsc;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic valid, input mdu_op_e op,
                         input logic flush, input logic d_hilo);
        reset           = rst;
        bus.e_valid     = valid;
        bus.e_mdu_op    = op;
        bus.e_flush     = flush;
        bus.d_uses_hilo = d_hilo;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds E empty and waits for mdu_done within a cycle budget; lat is the
    // number of cycles after the start cycle at which done was seen.
    task automatic wait_done(input logic d_hilo, output int lat);
        lat = 1;
        drive(1'b0, 1'b0, MDU_NOP, 1'b0, d_hilo);
        @(negedge clk);
        while (bus.mdu_done !== 1'b1 && lat < 20) begin
            next_cycle();
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;

        //        rst valid op      fl d  reps  start ctrl    busy done stall err sc
        vecs.push_back(mk(1, 0, MDU_NOP, 0, 0, 2,  0, MDU_NOP, 0, 0, 0, 0, 0));
        // mult with mflo waiting in D
        vecs.push_back(mk(0, 1, MULT,    0, 1, 1,  1, MULT,    0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 1,  0, MDU_NOP, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 1,  0, MDU_NOP, 1, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 1,  0, MDU_NOP, 1, 0, 1, 0, 3));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 1,  0, MDU_NOP, 1, 0, 1, 0, 4));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 1,  0, MDU_NOP, 1, 1, 0, 0, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 1,  0, MDU_NOP, 0, 0, 0, 0, 5));
        // flushed mult: dropped, no stall for mfhi in D
        vecs.push_back(mk(0, 1, MULT,    1, 1, 1,  0, MDU_NOP, 0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 1,  0, MDU_NOP, 0, 0, 0, 0, 5));
        // divu, then divu again as soon as busy drops
        vecs.push_back(mk(0, 1, DIVU,    0, 0, 1,  1, DIVU,    0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 9,  0, MDU_NOP, 1, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 1,  0, MDU_NOP, 1, 1, 0, 0, 5));
        vecs.push_back(mk(0, 1, DIVU,    0, 0, 1,  1, DIVU,    0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 3,  0, MDU_NOP, 1, 0, 0, 0, 5));
        // counter=7: mtlo goes through, then a mult is refused and flagged
        vecs.push_back(mk(0, 1, MTLO,    0, 0, 1,  1, MTLO,    1, 0, 0, 0, 5));
        vecs.push_back(mk(0, 1, MULT,    0, 0, 1,  0, MDU_NOP, 1, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 4,  0, MDU_NOP, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 1,  0, MDU_NOP, 1, 1, 0, 1, 5));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 1,  0, MDU_NOP, 0, 0, 0, 1, 5));
        // reset, then div interrupted by reset at counter=3
        vecs.push_back(mk(1, 0, MDU_NOP, 0, 0, 1,  0, MDU_NOP, 0, 0, 0, 1, 5));
        vecs.push_back(mk(0, 1, DIV,     0, 0, 1,  1, DIV,     0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 0, 7,  0, MDU_NOP, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, DIV,     0, 1, 1,  0, MDU_NOP, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, MDU_NOP, 0, 1, 10, 0, MDU_NOP, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].flush, vecs[i].d_hilo);
                @(negedge clk);
                check($sformatf("v%0d.%0d start", i, r), 32'(bus.mdu_start),   32'(vecs[i].x_start));
                check($sformatf("v%0d.%0d ctrl", i, r),  32'(bus.mdu_ctrl),    32'(vecs[i].x_ctrl));
                check($sformatf("v%0d.%0d busy", i, r),  32'(bus.mdu_busy),    32'(vecs[i].x_busy));
                check($sformatf("v%0d.%0d done", i, r),  32'(bus.mdu_done),    32'(vecs[i].x_done));
                check($sformatf("v%0d.%0d stall", i, r), 32'(bus.stall_d),     32'(vecs[i].x_stall));
                check($sformatf("v%0d.%0d err", i, r),   32'(bus.err_overlap), 32'(vecs[i].x_err));
                check($sformatf("v%0d.%0d scnt", i, r),  bus.stall_cycles,     vecs[i].x_sc);
                next_cycle();
            end
        end

        // Hand sequence: multu latency, stall count, back-to-back mult.
        drive(1'b1, 1'b0, MDU_NOP, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, MULTU, 1'b0, 1'b1);
        @(negedge clk);
        check("multu start", 32'(bus.mdu_start), 32'd1);
        check("multu ctrl", 32'(bus.mdu_ctrl), 32'(MULTU));
        next_cycle();
        wait_done(1'b1, lat);
        check("multu latency", 32'(lat), 32'd5);
        check("multu stall count", bus.stall_cycles, 32'd5);
        check("multu done stall", 32'(bus.stall_d), 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, MULT, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b busy", 32'(bus.mdu_busy), 32'd0);
        check("b2b start", 32'(bus.mdu_start), 32'd1);
        check("b2b stall", 32'(bus.stall_d), 32'd1);
        next_cycle();
        wait_done(1'b1, lat);
        check("b2b latency", 32'(lat), 32'd5);
        check("b2b stall count", bus.stall_cycles, 32'd10);
        check("b2b err", 32'(bus.err_overlap), 32'd0);
        next_cycle();
        @(negedge clk);
        check("b2b idle busy", 32'(bus.mdu_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
